// File: rtl/display_arbiter.sv
// display_arbiter: round-robin time-sharing of the 4-digit display among
// NUM_REQ producers, with minimum dwell per grant and a blank tick on hand-over.
// Ports: i_clk, i_clear (sync active-low), i_req[NUM_REQ], i_data[16*NUM_REQ],
//   i_mode_in[NUM_REQ] -> o_gnt (one-hot), o_active_id, o_d0..o_d3, o_mode, o_blank.
// Option: define DISPLAY_ARB_PREEMPT_EN to make requester 0 preempt others.
module display_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TICK_BITS = 20,
  parameter int DWELL     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_clear,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [16*NUM_REQ-1:0]  i_data,
  input  logic [NUM_REQ-1:0]     i_mode_in,
  output logic [NUM_REQ-1:0]     o_gnt,
  output logic [2:0]             o_active_id,
  output logic [3:0]             o_d0,
  output logic [3:0]             o_d1,
  output logic [3:0]             o_d2,
  output logic [3:0]             o_d3,
  output logic                   o_mode,
  output logic                   o_blank
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWITCH,
    S_SHOW
  } state_t;

  localparam logic [7:0] DW  = 8'(DWELL);
  localparam logic [7:0] DW1 = 8'(DWELL - 1);
  localparam logic [2:0] LAST = 3'(NUM_REQ - 1);

  state_t               r_state;
  logic [TICK_BITS-1:0] r_presc;
  logic [7:0]           r_dwell;
  logic [2:0]           r_rr_ptr;
  logic [2:0]           r_active_id;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [15:0]          r_digits;
  logic                 r_mode;
  logic                 r_blank;
`ifdef DISPLAY_ARB_PREEMPT_EN
  logic                 r_req0;
`endif

  state_t               w_nstate;
  logic [2:0]           w_nid;
  logic [2:0]           w_nrr;
  logic [7:0]           w_ndwell;
  logic [NUM_REQ-1:0]   w_ngnt;
  logic                 w_tick;
  logic [2:0]           w_ptr_inc;
  logic [3:0]           w_pick_rr;
  logic [3:0]           w_pick_nx;
  logic [7:0]           w_req8;
  logic                 w_holder;
  logic                 w_others;
  logic                 w_dwell_done;
  logic [15:0]          w_sel;
  logic                 w_msel;

  // First asserted request searching upward from base, wrapping.
  // Returns {found, index}.
  function automatic logic [3:0] f_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [2:0]         base
  );
    logic [3:0] res;
    int         idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % NUM_REQ;
      if (req[idx]) res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

  assign w_tick    = &r_presc;
  assign w_ptr_inc = (r_active_id == LAST) ? 3'd0 : r_active_id + 3'd1;
  assign w_pick_rr = f_pick(i_req, r_rr_ptr);
  assign w_pick_nx = f_pick(i_req, w_ptr_inc);
  assign w_req8    = 8'(i_req);
  assign w_holder  = w_req8[r_active_id];
  assign w_others  = |(i_req & ~r_gnt);
  // Include this cycle's tick so a grant lasts exactly DWELL ticks.
  assign w_dwell_done = (r_dwell == DW) || (w_tick && r_dwell == DW1);

  always_comb begin
    w_nstate = r_state;
    w_nid    = r_active_id;
    w_nrr    = r_rr_ptr;
    w_ndwell = r_dwell;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_rr[3]) begin
          w_nstate = S_SWITCH;
          w_nid    = w_pick_rr[2:0];
        end
      end
      S_SWITCH: begin
        if (!w_holder) begin
          w_nstate = w_pick_rr[3] ? S_SWITCH : S_IDLE;
          w_nid    = w_pick_rr[3] ? w_pick_rr[2:0] : 3'd0;
        end else if (w_tick) begin
          w_nstate = S_SHOW;
          w_ndwell = 8'd0;
        end
      end
      S_SHOW: begin
        if (!w_holder) begin
          w_nrr    = w_ptr_inc;
          w_nstate = w_pick_nx[3] ? S_SWITCH : S_IDLE;
          w_nid    = w_pick_nx[3] ? w_pick_nx[2:0] : 3'd0;
        end else if (w_dwell_done && w_others) begin
          w_nrr    = w_ptr_inc;
          w_nstate = S_SWITCH;
          w_nid    = w_pick_nx[2:0];
        end else if (w_tick && r_dwell != DW) begin
          w_ndwell = r_dwell + 8'd1;
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_nid    = 3'd0;
      end
    endcase
`ifdef DISPLAY_ARB_PREEMPT_EN
    if (r_state != S_IDLE && r_active_id != 3'd0 &&
        i_req[0] && !r_req0) begin
      w_nstate = S_SWITCH;
      w_nid    = 3'd0;
      w_nrr    = r_rr_ptr;
      w_ndwell = r_dwell;
    end
`endif
    w_ngnt = (w_nstate == S_IDLE) ? '0 : (NUM_REQ'(1) << w_nid);
  end

  always_comb begin
    w_sel  = 16'h0000;
    w_msel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_nid == 3'(i)) begin
        w_sel  = i_data[16*i +: 16];
        w_msel = i_mode_in[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clear) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_dwell     <= 8'd0;
      r_rr_ptr    <= 3'd0;
      r_active_id <= 3'd0;
      r_gnt       <= '0;
      r_digits    <= 16'h0000;
      r_mode      <= 1'b0;
      r_blank     <= 1'b1;
`ifdef DISPLAY_ARB_PREEMPT_EN
      r_req0      <= 1'b0;
`endif
    end else begin
      r_presc     <= r_presc + TICK_BITS'(1);
      r_state     <= w_nstate;
      r_dwell     <= w_ndwell;
      r_rr_ptr    <= w_nrr;
      r_active_id <= w_nid;
      r_gnt       <= w_ngnt;
`ifdef DISPLAY_ARB_PREEMPT_EN
      r_req0      <= i_req[0];
`endif
      if (w_nstate == S_SHOW) begin
        r_digits <= w_sel;
        r_mode   <= w_msel;
        r_blank  <= 1'b0;
      end else begin
        r_digits <= 16'h0000;
        r_mode   <= 1'b0;
        r_blank  <= 1'b1;
      end
    end
  end

  assign o_gnt       = r_gnt;
  assign o_active_id = r_active_id;
  assign o_d0        = r_digits[3:0];
  assign o_d1        = r_digits[7:4];
  assign o_d2        = r_digits[11:8];
  assign o_d3        = r_digits[15:12];
  assign o_mode      = r_mode;
  assign o_blank     = r_blank;

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed checks of display_arbiter with
// TICK_BITS=2, DWELL=2, NUM_REQ=4 (tick on every 4th clock).
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        clear;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  mode_in;
  logic [3:0]  gnt;
  logic [2:0]  active_id;
  logic [3:0]  d0, d1, d2, d3;
  logic        mode;
  logic        blank;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  display_arbiter #(
    .NUM_REQ  (4),
    .TICK_BITS(2),
    .DWELL    (2)
  ) dut (
    .i_clk      (clk),
    .i_clear    (clear),
    .i_req      (req),
    .i_data     (data),
    .i_mode_in  (mode_in),
    .o_gnt      (gnt),
    .o_active_id(active_id),
    .o_d0       (d0),
    .o_d1       (d1),
    .o_d2       (d2),
    .o_d3       (d3),
    .o_mode     (mode),
    .o_blank    (blank)
  );

  always #5 clk = ~clk;

  task automatic goto(input int e);
    while (cyc < e) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] digs();
    return {16'h0, d3, d2, d1, d0};
  endfunction

  initial begin
    clear   = 1'b0;
    req     = 4'b1111;
    data    = {16'hCDEF, 16'h1234, 16'h5678, 16'h0F0E};
    mode_in = 4'b0110;

    goto(3);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_blank", blank, 1'b1);
    check("rst_digits", digs(), 16'h0000);
    check("rst_id", active_id, 3'd0);
    clear = 1'b1;

    goto(4);
    check("first_gnt", gnt, 4'b0001);
    check("first_id", active_id, 3'd0);
    req = 4'b1011;

    goto(6);
    check("sw0_blank", blank, 1'b1);
    goto(7);
    check("show0_blank", blank, 1'b0);
    check("show0_digits", digs(), 16'h0F0E);
    check("show0_mode", mode, 1'b0);
    goto(14);
    check("show0_hold", gnt, 4'b0001);
    goto(15);
    check("rot1_gnt", gnt, 4'b0010);
    check("rot1_blank", blank, 1'b1);
    goto(18);
    check("rot1_still_blank", blank, 1'b1);
    goto(19);
    check("show1_blank", blank, 1'b0);
    check("show1_digits", digs(), 16'h5678);
    check("show1_mode", mode, 1'b1);
    goto(26);
    check("show1_hold", gnt, 4'b0010);
    goto(27);
    check("rot3_gnt", gnt, 4'b1000);
    check("rot3_id", active_id, 3'd3);
    goto(31);
    check("show3_digits", digs(), 16'hCDEF);
    goto(39);
    check("wrap0_gnt", gnt, 4'b0001);
    check("wrap0_id", active_id, 3'd0);

    goto(55);
    check("show1b_gnt", gnt, 4'b0010);
    check("show1b_blank", blank, 1'b0);
    req = 4'b1001;
    goto(56);
    check("early_rel_gnt", gnt, 4'b1000);
    check("early_rel_blank", blank, 1'b1);
    goto(59);
    check("show3b_blank", blank, 1'b0);
    req = 4'b0000;
    goto(60);
    check("idle_gnt", gnt, 4'b0000);
    check("idle_blank", blank, 1'b1);

    req = 4'b0100;
    goto(61);
    check("single_gnt", gnt, 4'b0100);
    goto(62);
    check("single_blank", blank, 1'b1);
    goto(63);
    check("single_blank_off", blank, 1'b0);
    check("single_digits", digs(), 16'h1234);
    check("single_mode", mode, 1'b1);
    goto(90);
    check("single_stay_gnt", gnt, 4'b0100);
    check("single_stay_blank", blank, 1'b0);

    data[47:32] = 16'h0000;
    goto(91);
    check("track_zero", digs(), 16'h0000);
    data[47:32] = 16'h9ABC;
    #2;
    check("track_latency", digs(), 16'h0000);
    goto(92);
    check("track_new", digs(), 16'h9ABC);

    req = 4'b1100;
    goto(93);
    check("sat_rot_gnt", gnt, 4'b1000);
    check("sat_rot_blank", blank, 1'b1);

    clear = 1'b0;
    goto(94);
    check("midrst_gnt", gnt, 4'b0000);
    check("midrst_blank", blank, 1'b1);
    check("midrst_id", active_id, 3'd0);
    clear = 1'b1;
    req   = 4'b0100;
    goto(95);
    check("pre_gnt", gnt, 4'b0100);
    goto(98);
    check("pre_show", blank, 1'b0);
    req = 4'b0101;
    goto(99);
`ifdef DISPLAY_ARB_PREEMPT_EN
    check("preempt_gnt", gnt, 4'b0001);
    goto(102);
    check("preempt_show", blank, 1'b0);
    req = 4'b0100;
    goto(103);
    check("preempt_return", gnt, 4'b0100);
`else
    check("no_preempt_gnt", gnt, 4'b0100);
    check("no_preempt_blank", blank, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
